iomem_master: RTL and testbench
===============================

// Module: iomem_master
// PURPOSE
// - Initiator end of the iomem bus (valid/ready/wstrb/addr/wdata/rdata) that our memory model and RAM-delay responder serve.
// - Converts core load/store requests (valid/ready) into single iomem transactions.
// - Holds each bus request until the memory's ready and returns a registered response to the core.
// - Sits between the core LSU/fetch arbiter and the external iomem port of islemci.
// PARAMETERS
// - ADDR_WIDTH      32    byte-address width of req_addr_i / iomem_addr_o
// - DATA_WIDTH      32    data width; wstrb width = DATA_WIDTH/8
// - TIMEOUT_CYCLES  256   bus watchdog limit in cycles (used only with IOMEM_TIMEOUT_EN)
// PORTS
// - clk_i           in   1     clock, all logic on posedge
// - rst_i           in   1     synchronous, active-high reset
// - req_valid_i     in   1     core request valid
// - req_ready_o     out  1     block can accept a request
// - req_addr_i      in   32    byte address
// - req_wdata_i     in   32    store data
// - req_wstrb_i     in   4     byte enables; 0 = read
// - resp_valid_o    out  1     response valid
// - resp_ready_i    in   1     core accepts response
// - resp_rdata_o    out  32    read data (0 for writes)
// - resp_err_o      out  1     transaction timed out
// - iomem_valid_o   out  1     bus request valid
// - iomem_ready_i   in   1     bus completion strobe from the responder
// - iomem_wstrb_o   out  4     bus byte enables
// - iomem_addr_o    out  32    word-aligned bus address
// - iomem_wdata_o   out  32    bus write data
// - iomem_rdata_i   in   32    bus read data, valid while iomem_ready_i is high
// - stat_stall_o    out  32    saturating count of cycles with iomem_valid_o=1 and iomem_ready_i=0
// BEHAVIOUR
// - Reset values: req_ready_o=0 in the reset cycle, then 1; every other output=0; state=IDLE; stat_stall_o=0.
// - FSM states: IDLE, BUS, RESP.
//   - IDLE->BUS on req_valid_i & req_ready_o. req_ready_o = (state==IDLE) & !rst_i.
//   - BUS->RESP on the edge where iomem_ready_i=1.
//   - RESP->IDLE on resp_ready_i=1.
// - Accept edge (cycle 0):
//   - addr, wdata and wstrb are registered.
//   - iomem_addr_o = {req_addr_i[31:2],2'b00}.
//   - iomem_valid_o=1 from cycle 1.
// - BUS state:
//   - iomem_valid_o, addr, wdata and wstrb are held stable until iomem_ready_i is sampled high.
//   - No combinational path from iomem_ready_i to iomem_valid_o.
// - Completion edge:
//   - iomem_valid_o drops on that edge.
//   - resp_rdata_o captures iomem_rdata_i if wstrb==0, else 0.
//   - resp_valid_o=1 next cycle and is held until resp_ready_i.
// - iomem_ready_i outside BUS is ignored; no state change, no response.
// - Minimum latency is accept-to-resp_valid_o = 2 cycles (ready in the first BUS cycle); each extra responder delay cycle adds 1.
// - Back-to-back: the next request is accepted only in IDLE, so a minimum of 3 cycles per transaction.
// - stat_stall_o increments while in BUS with iomem_ready_i=0 and saturates at 32'hFFFF_FFFF.
// - rst_i asserted mid-transaction:
//   - iomem_valid_o=0 and resp_valid_o=0 on the next edge.
//   - The pending request and response are discarded.
//   - stat_stall_o is cleared.
// - resp_err_o is 0 whenever resp_valid_o is 0.
// CONFIGURATION
// - IOMEM_TIMEOUT_EN defined:
//   - A counter runs in BUS.
//   - If TIMEOUT_CYCLES consecutive BUS cycles pass without iomem_ready_i, the block goes BUS->RESP.
//   - On timeout: iomem_valid_o drops, resp_err_o=1, resp_rdata_o=0.
//   - If iomem_ready_i arrives in the expiry cycle, the ready wins and resp_err_o=0.
// - IOMEM_TIMEOUT_EN undefined:
//   - No counter is built; BUS waits indefinitely.
//   - resp_err_o is tied 0.
// TESTING
// - Read, 1-cycle delay:
//   - Stimulus: req addr=0x4000_0006, wstrb=0.
//   - Response: iomem_addr_o=0x4000_0004; resp_rdata_o = mem word; resp_valid_o 2 cycles after accept; stat_stall_o=0.
// - Write, 3-cycle delay:
//   - Stimulus: addr=0x4000_0010, wdata=0xDEAD_BEEF, wstrb=4'b0011.
//   - Response: bus signals stable for 3 cycles; the model stores 0xBEEF in the low half; resp_rdata_o=0; stat_stall_o=2.
// - Response backpressure:
//   - Stimulus: resp_ready_i=0 for 5 cycles.
//   - Response: resp_valid_o held with stable data; req_ready_o=0 throughout; a new req is accepted the cycle after the resp handshake.
// - Stray ready and reset:
//   - Stimulus 1: pulse iomem_ready_i in IDLE.
//     - Response: no resp_valid_o.
//   - Stimulus 2: assert rst_i in BUS.
//     - Response: iomem_valid_o=0 next cycle; no response is ever produced.
// - Timeout (IOMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8):
//   - Stimulus 1: responder never readies.
//     - Response: resp_err_o=1 with resp_rdata_o=0 after 8 BUS cycles.
//   - Stimulus 2: ready in the 8th cycle.
//     - Response: resp_err_o=0.
// - Random stream of 1000 read/write mixes with RAM delay 1..4:
//   - Response: model contents and all read data match a scoreboard; one bus transaction per request.

Source files
------------

// File: rtl/iomem_master.sv
// iomem_master: initiator end of the iomem bus.
// Turns one core load/store request into one iomem transaction, holds the
// bus request until the responder completes it, then returns a registered
// response to the core.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid, once raised, is held with stable payload until that
// transfer. req_ready_o is high only in IDLE and outside reset. resp_valid_o
// is held with stable data until resp_ready_i. iomem_valid_o is held with
// stable addr/wdata/wstrb until iomem_ready_i is sampled high.
//
// Optional feature: define IOMEM_TIMEOUT_EN to build a bus watchdog. After
// TIMEOUT_CYCLES consecutive BUS cycles without iomem_ready_i, the block
// abandons the transfer and responds with resp_err_o=1. If the macro is not
// defined, no counter exists, BUS waits indefinitely and resp_err_o is 0.
module iomem_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    iomem_valid_o,
  input  logic                    iomem_ready_i,
  output logic [DATA_WIDTH/8-1:0] iomem_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   iomem_addr_o,
  output logic [DATA_WIDTH-1:0]   iomem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   iomem_rdata_i,
  output logic [31:0]             stat_stall_o,
  output logic [1:0]              dbg_state_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // A zero-cycle watchdog limit has no meaning; reject it at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("iomem_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q,       state_d;
  logic                    iomem_valid_q, iomem_valid_d;
  logic [ADDR_WIDTH-1:0]   addr_q,        addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,       wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q,       wstrb_d;
  logic                    resp_valid_q,  resp_valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q,       rdata_d;
  logic [31:0]             stall_q,       stall_d;

`ifdef IOMEM_TIMEOUT_EN
  localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic                    err_q,         err_d;
  logic [TMO_WIDTH-1:0]    tmo_q,         tmo_d;
`endif

  // Ready depends on reset directly so no request is taken in a reset cycle.
  assign req_ready_o   = (state_q == IDLE) && !rst_i;

  assign iomem_valid_o = iomem_valid_q;
  assign iomem_addr_o  = addr_q;
  assign iomem_wdata_o = wdata_q;
  assign iomem_wstrb_o = wstrb_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_rdata_o  = rdata_q;
  assign stat_stall_o  = stall_q;
  assign dbg_state_o   = state_q;

`ifdef IOMEM_TIMEOUT_EN
  assign resp_err_o    = err_q;
`else
  assign resp_err_o    = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE/BUS/RESP sequencer.
  always_comb begin
    state_d       = state_q;
    iomem_valid_d = iomem_valid_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    resp_valid_d  = resp_valid_q;
    rdata_d       = rdata_q;
    stall_d       = stall_q;
`ifdef IOMEM_TIMEOUT_EN
    err_d         = err_q;
    tmo_d         = tmo_q;
`endif

    // Stall cycles: bus request outstanding and responder not ready.
    if ((state_q == BUS) && !iomem_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          state_d       = BUS;
          iomem_valid_d = 1'b1;
          addr_d        = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          wdata_d       = req_wdata_i;
          wstrb_d       = req_wstrb_i;
`ifdef IOMEM_TIMEOUT_EN
          tmo_d         = '0;
`endif
        end
      end

      BUS: begin
        if (iomem_ready_i) begin
          // A completion in the expiry cycle still counts as a good transfer.
          state_d       = RESP;
          iomem_valid_d = 1'b0;
          resp_valid_d  = 1'b1;
          rdata_d       = (wstrb_q == '0) ? iomem_rdata_i : '0;
`ifdef IOMEM_TIMEOUT_EN
          err_d         = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d       = RESP;
          iomem_valid_d = 1'b0;
          resp_valid_d  = 1'b1;
          rdata_d       = '0;
          err_d         = 1'b1;
        end else begin
          tmo_d         = tmo_q + 1'b1;
`endif
        end
      end

      RESP: begin
        if (resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = '0;
`ifdef IOMEM_TIMEOUT_EN
          err_d        = 1'b0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any pending work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      iomem_valid_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      resp_valid_q  <= 1'b0;
      rdata_q       <= '0;
      stall_q       <= '0;
`ifdef IOMEM_TIMEOUT_EN
      err_q         <= 1'b0;
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      iomem_valid_q <= iomem_valid_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      resp_valid_q  <= resp_valid_d;
      rdata_q       <= rdata_d;
      stall_q       <= stall_d;
`ifdef IOMEM_TIMEOUT_EN
      err_q         <= err_d;
      tmo_q         <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_iomem_master.sv
// Testbench for iomem_master: directed vector table, hand-written corner
// sequences (backpressure, stray ready, reset in BUS, optional timeout) and
// a random read/write stream against a RAM responder with delay 1..4.
module tb_iomem_master;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        iomem_valid_o;
  logic        iomem_ready_i;
  logic [3:0]  iomem_wstrb_o;
  logic [31:0] iomem_addr_o;
  logic [31:0] iomem_wdata_o;
  logic [31:0] iomem_rdata_i;
  logic [31:0] stat_stall_o;
  logic [1:0]  dbg_state_o;

  iomem_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_wstrb_i   (req_wstrb_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_rdata_o  (resp_rdata_o),
    .resp_err_o    (resp_err_o),
    .iomem_valid_o (iomem_valid_o),
    .iomem_ready_i (iomem_ready_i),
    .iomem_wstrb_o (iomem_wstrb_o),
    .iomem_addr_o  (iomem_addr_o),
    .iomem_wdata_o (iomem_wdata_o),
    .iomem_rdata_i (iomem_rdata_i),
    .stat_stall_o  (stat_stall_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[16];      // responder RAM
  logic [31:0] ref_mem[16];  // bench reference of what RAM must hold
  bit          rsp_en    = 1'b0;
  int          rsp_delay = 1;
  int          bus_cnt   = 0;
  int          n_txn     = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  // ---------------- RAM responder ----------------
  // Raises ready in the rsp_delay-th BUS cycle; commits writes after completion.
  initial begin
    int          cnt;
    bit          pend;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;
    cnt  = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_en) begin
        if (pend) begin
          mem[p_addr[5:2]] = merge(mem[p_addr[5:2]], p_wdata, p_wstrb);
          pend          = 1'b0;
          cnt           = 0;
          bus_cnt++;
          iomem_ready_i = 1'b0;
        end else if (iomem_valid_o) begin
          if (cnt >= rsp_delay - 1) begin
            iomem_ready_i = 1'b1;
            iomem_rdata_i = (iomem_wstrb_o == 4'h0) ? mem[iomem_addr_o[5:2]] : $urandom;
            p_addr        = iomem_addr_o;
            p_wdata       = iomem_wdata_o;
            p_wstrb       = iomem_wstrb_o;
            pend          = 1'b1;
          end else begin
            iomem_ready_i = 1'b0;
            cnt++;
          end
        end else begin
          iomem_ready_i = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returns at a negedge with the DUT idle.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay,
                         input logic [31:0] exp_rdata);
    int          n;
    logic [31:0] stall0;
    logic [31:0] got;
    rsp_delay = delay;
    stall0    = stat_stall_o;
    check("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = wstrb;
    exp_q.push_back(exp_rdata);
    n_txn++;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 1;
    while (!resp_valid_o && n < 40) begin
      check("bus_valid", {31'd0, iomem_valid_o}, 32'd1);
      check("bus_addr",  iomem_addr_o, {addr[31:2], 2'b00});
      check("bus_wdata", iomem_wdata_o, wdata);
      check("bus_wstrb", {28'd0, iomem_wstrb_o}, {28'd0, wstrb});
      @(negedge clk);
      n++;
    end
    check("resp_seen",    {31'd0, resp_valid_o}, 32'd1);
    check("resp_latency", n, delay + 1);
    check("resp_err",     {31'd0, resp_err_o}, 32'd0);
    check("bus_dropped",  {31'd0, iomem_valid_o}, 32'd0);
    check("stall_delta",  stat_stall_o - stall0, delay - 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      check("resp_rdata", resp_rdata_o, got);
    end
    @(negedge clk);
    check("resp_cleared", {31'd0, resp_valid_o}, 32'd0);
  endtask

  task automatic wait_resp(output int n);
    n = 1;
    while (!resp_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_resp", {31'd0, resp_valid_o}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          n;
    logic [31:0] a, wd, e;
    logic [3:0]  st;
    logic [31:0] held;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst_i         = 1'b1;
    req_valid_i   = 1'b0;
    req_addr_i    = 32'h0;
    req_wdata_i   = 32'h0;
    req_wstrb_i   = 4'h0;
    resp_ready_i  = 1'b1;
    iomem_ready_i = 1'b0;
    iomem_rdata_i = 32'h0;

    vecs[0] = '{32'h4000_0006, 32'h0000_0000, 4'b0000, 1, 32'h0000_0000};
    vecs[1] = '{32'h4000_0010, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0000_0000};
    vecs[2] = '{32'h4000_0012, 32'h0000_0000, 4'b0000, 1, 32'h0000_BEEF};
    vecs[3] = '{32'h4000_0004, 32'h1234_5678, 4'b1111, 2, 32'h0000_0000};
    vecs[4] = '{32'h4000_0006, 32'h0000_0000, 4'b0000, 1, 32'h1234_5678};
    vecs[5] = '{32'h4000_0004, 32'hAABB_CCDD, 4'b1000, 4, 32'h0000_0000};
    vecs[6] = '{32'h4000_0007, 32'h0000_0000, 4'b0000, 2, 32'hAA34_5678};
    vecs[7] = '{32'h4000_0010, 32'h1122_3344, 4'b0100, 1, 32'h0000_0000};
    vecs[8] = '{32'h4000_0013, 32'h0000_0000, 4'b0000, 3, 32'h0022_BEEF};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready_o}, 32'd0);
    check("rst_iomem_vld",  {31'd0, iomem_valid_o}, 32'd0);
    check("rst_resp_vld",   {31'd0, resp_valid_o}, 32'd0);
    check("rst_addr",       iomem_addr_o, 32'd0);
    check("rst_wdata",      iomem_wdata_o, 32'd0);
    check("rst_wstrb",      {28'd0, iomem_wstrb_o}, 32'd0);
    check("rst_rdata",      resp_rdata_o, 32'd0);
    check("rst_err",        {31'd0, resp_err_o}, 32'd0);
    check("rst_stall",      stat_stall_o, 32'd0);
    check("rst_state",      {30'd0, dbg_state_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);

    // Directed vector table.
    rsp_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wstrb != 4'h0) begin
        ref_mem[vecs[i].addr[5:2]] = merge(ref_mem[vecs[i].addr[5:2]], vecs[i].wdata, vecs[i].wstrb);
      end
      run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].delay, vecs[i].exp_rdata);
      if (i == 0) check("first_read_stall", stat_stall_o, 32'd0);
      if (i == 1) check("write_low_half", mem[4], 32'h0000_BEEF);
    end

    // Response backpressure with a second request waiting.
    resp_ready_i = 1'b0;
    rsp_delay    = 2;
    req_valid_i  = 1'b1;
    req_addr_i   = 32'h4000_0004;
    req_wdata_i  = 32'h0;
    req_wstrb_i  = 4'h0;
    exp_q.push_back(ref_mem[1]);
    n_txn++;
    @(negedge clk);
    req_valid_i = 1'b0;
    wait_resp(n);
    held = resp_rdata_o;
    check("bp_first_data", held, exp_q[0]);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h4000_0009;
    req_wdata_i = 32'h0BAD_F00D;
    req_wstrb_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_held",  {31'd0, resp_valid_o}, 32'd1);
      check("bp_data_held",  resp_rdata_o, held);
      check("bp_req_ready",  {31'd0, req_ready_o}, 32'd0);
      check("bp_no_bus",     {31'd0, iomem_valid_o}, 32'd0);
    end
    e = exp_q.pop_front();
    check("bp_rdata", resp_rdata_o, e);
    resp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_resp_done",  {31'd0, resp_valid_o}, 32'd0);
    check("bp_ready_back", {31'd0, req_ready_o}, 32'd1);
    check("bp_not_yet",    {31'd0, iomem_valid_o}, 32'd0);
    ref_mem[2] = merge(ref_mem[2], 32'h0BAD_F00D, 4'hF);
    exp_q.push_back(32'h0);
    n_txn++;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("bp_second_acc",  {31'd0, iomem_valid_o}, 32'd1);
    check("bp_second_addr", iomem_addr_o, 32'h4000_0008);
    wait_resp(n);
    e = exp_q.pop_front();
    check("bp_second_rdata", resp_rdata_o, e);
    @(negedge clk);

    // Stray ready in IDLE.
    rsp_en = 1'b0;
    @(negedge clk);
    held = stat_stall_o;
    iomem_ready_i = 1'b1;
    iomem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    iomem_ready_i = 1'b0;
    check("stray_no_resp",  {31'd0, resp_valid_o}, 32'd0);
    check("stray_idle",     {30'd0, dbg_state_o}, 32'd0);
    check("stray_ready",    {31'd0, req_ready_o}, 32'd1);
    check("stray_stall",    stat_stall_o, held);
    @(negedge clk);
    check("stray_no_resp2", {31'd0, resp_valid_o}, 32'd0);

    // Reset asserted while in BUS.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h4000_0020;
    req_wstrb_i = 4'h0;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rb_in_bus", {31'd0, iomem_valid_o}, 32'd1);
    @(negedge clk);
    check("rb_stalled", stat_stall_o, held + 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rb_valid_drop", {31'd0, iomem_valid_o}, 32'd0);
    check("rb_no_resp",    {31'd0, resp_valid_o}, 32'd0);
    check("rb_stall_clr",  stat_stall_o, 32'd0);
    check("rb_state",      {30'd0, dbg_state_o}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      iomem_ready_i = i[0];
      @(negedge clk);
      check("rb_never_resp", {31'd0, resp_valid_o}, 32'd0);
    end
    iomem_ready_i = 1'b0;

`ifdef IOMEM_TIMEOUT_EN
    // Watchdog expiry with no ready at all.
    held = stat_stall_o;
    req_valid_i = 1'b1;
    req_addr_i  = 32'h4000_0024;
    req_wstrb_i = 4'h0;
    @(negedge clk);
    req_valid_i = 1'b0;
    wait_resp(n);
    check("tmo_latency", n, 9);
    check("tmo_err",     {31'd0, resp_err_o}, 32'd1);
    check("tmo_rdata",   resp_rdata_o, 32'd0);
    check("tmo_bus_off", {31'd0, iomem_valid_o}, 32'd0);
    check("tmo_stall",   stat_stall_o - held, 32'd8);
    @(negedge clk);
    check("tmo_err_clr", {31'd0, resp_err_o}, 32'd0);
    // Ready arriving in the expiry cycle wins.
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 1;
    while (!resp_valid_o && n < 40) begin
      iomem_ready_i = (n == 8);
      iomem_rdata_i = 32'h5A5A_1234;
      @(negedge clk);
      n++;
    end
    iomem_ready_i = 1'b0;
    check("tmo_race_lat",   n, 9);
    check("tmo_race_err",   {31'd0, resp_err_o}, 32'd0);
    check("tmo_race_rdata", resp_rdata_o, 32'h5A5A_1234);
    @(negedge clk);
`endif

    // Random read/write stream.
    rsp_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a  = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wd = $urandom;
      st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (st == 4'h0) begin
        e = ref_mem[a[5:2]];
      end else begin
        e = 32'h0;
        ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], wd, st);
      end
      run_txn(a, wd, st, $urandom_range(1, 4), e);
    end
    @(negedge clk);

    // End-of-run consistency.
    check("bus_txn_count", bus_cnt, n_txn);
    check("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) begin
      check("mem_contents", mem[i], ref_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
